// File: rtl/testbench_ls_ram_pkg.sv
// Shared constants and types for the RAM stream reader.
// The RAM is a 128000 x 32 word array, addressed through 17-bit word addresses.
package testbench_ls_ram_pkg;

  localparam int RAM_AW    = 17;
  localparam int RAM_WORDS = 128000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } beat_t;

  // The end of the range is computed one bit wider so that it cannot wrap.
  function automatic logic cmd_in_range(input logic [RAM_AW-1:0] addr,
                                        input logic [RAM_AW-1:0] count);
    logic [RAM_AW:0] end_excl;
    end_excl = {1'b0, addr} + {1'b0, count};
    return end_excl <= (RAM_AW+1)'(RAM_WORDS);
  endfunction

endpackage

// File: rtl/testbench_ls_sc_fifo.sv
// Show-ahead single-clock FIFO of data words with sop/eop sideband.
// The head entry is visible on rd_beat_o whenever empty_o is low.
module testbench_ls_sc_fifo
  import testbench_ls_ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  beat_t                  wr_beat_i,
  input  logic                   rd_en_i,
  output beat_t                  rd_beat_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] used_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_L = (PW+1)'(DEPTH);

  beat_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   used_q, used_d;
  logic          do_rd;

  assign do_rd = rd_en_i && (used_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_rd)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en_i, do_rd})
      2'b10:   used_d = used_q + (PW+1)'(1);
      2'b01:   used_d = used_q - (PW+1)'(1);
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_beat_i;
  end

  assign rd_beat_o = mem_q[rd_ptr_q];
  assign empty_o   = (used_q == '0);
  assign used_o    = used_q;

  // Upstream credit accounting must never let a write land on a full FIFO without a read.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(wr_en_i && !do_rd && (used_q == FULL_L)));

endmodule

// File: rtl/testbench_ls_ram_stream_reader.sv
// Avalon-MM read master that fetches a contiguous RAM word range and replays it as an Avalon-ST packet.
// State | Meaning
// IDLE  | waiting for cmd_start; out-of-range commands pulse cmd_err, empty ones pulse done
// RUN   | issuing one read per cycle while FIFO credits remain
// DRAIN | every read issued; waiting for the in-flight word and the FIFO to empty
module testbench_ls_ram_stream_reader
  import testbench_ls_ram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [RAM_AW-1:0] cmd_addr,
  input  logic [RAM_AW-1:0] cmd_count,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [RAM_AW-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic [31:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop
);

  localparam int UW = $clog2(FIFO_DEPTH);
  localparam logic [UW:0] DEPTH_L = (UW+1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [RAM_AW-1:0] remain_q, remain_d;
  logic              first_q, first_d;
  logic              inflight_q;
  logic              pend_sop_q, pend_eop_q;
  logic              done_zero_q, done_zero_d;
  logic              err_q, err_d;

  logic              issue;
  logic              credit_ok;
  logic              done_drain;
  logic              fifo_empty;
  logic [UW:0]       fifo_used;
  beat_t             wr_beat;
  beat_t             rd_beat;

  // Words already buffered plus the one on the RAM bus must leave room for another read.
  assign credit_ok = (fifo_used + {{UW{1'b0}}, inflight_q}) < DEPTH_L;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    first_d     = first_q;
    done_zero_d = 1'b0;
    err_d       = 1'b0;
    issue       = 1'b0;
    done_drain  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          if (!cmd_in_range(cmd_addr, cmd_count)) begin
            err_d = 1'b1;
          end else if (cmd_count == '0) begin
            done_zero_d = 1'b1;
          end else begin
            addr_d   = cmd_addr;
            remain_d = cmd_count;
            first_d  = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue    = 1'b1;
          addr_d   = addr_q + RAM_AW'(1);
          remain_d = remain_q - RAM_AW'(1);
          first_d  = 1'b0;
          if (remain_q == RAM_AW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          done_drain = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      first_q     <= 1'b0;
      inflight_q  <= 1'b0;
      pend_sop_q  <= 1'b0;
      pend_eop_q  <= 1'b0;
      done_zero_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      first_q     <= first_d;
      inflight_q  <= issue;
      pend_sop_q  <= issue && first_q;
      pend_eop_q  <= issue && (remain_q == RAM_AW'(1));
      done_zero_q <= done_zero_d;
      err_q       <= err_d;
    end
  end

  // RAM q for the read issued last cycle is captured together with its packet markers.
  assign wr_beat = {pend_sop_q, pend_eop_q, ram_readdata};

  testbench_ls_sc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (inflight_q),
    .wr_beat_i (wr_beat),
    .rd_en_i   (src_ready),
    .rd_beat_o (rd_beat),
    .empty_o   (fifo_empty),
    .used_o    (fifo_used)
  );

  assign busy           = (state_q != IDLE);
  assign done           = done_drain || done_zero_q;
  assign cmd_err        = err_q;
  assign ram_address    = addr_q;
  assign ram_chipselect = issue;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign src_valid      = !fifo_empty;
  assign src_data       = rd_beat.data;
  assign src_sop        = rd_beat.sop;
  assign src_eop        = rd_beat.eop;

endmodule

// File: tb/tb_testbench_ls_ram_stream_reader.sv
// Directed bench for the RAM stream reader: a behavioural RAM, a bus monitor, and one task per scenario.
module tb_testbench_ls_ram_stream_reader;
  import testbench_ls_ram_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [16:0] cmd_addr = '0;
  logic [16:0] cmd_count = '0;
  logic        busy, done, cmd_err;
  logic [16:0] ram_address;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_readdata = '0;
  logic [31:0] src_data;
  logic        src_valid, src_sop, src_eop;
  logic        src_ready = 1'b1;

  int checks = 0;
  int passes = 0;

  testbench_ls_ram_stream_reader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .busy(busy), .done(done), .cmd_err(cmd_err),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input int a);
    logic [16:0] a17;
    a17 = a[16:0];
    return {15'h2B5C, a17};
  endfunction

  // RAM: address in cycle N, q valid in cycle N+1.
  always @(posedge clk) if (ram_chipselect) ram_readdata <= word_of(int'(ram_address));

  int          cyc = 0, issued = 0, xferred = 0;
  int          done_cnt = 0, err_cnt = 0, busy_cnt = 0, cs_cnt = 0;
  int          over_cnt = 0, low_full_cnt = 0, hold_viol = 0, done_cyc = -1;
  logic [31:0] b_data[$];
  logic        b_sop[$];
  logic        b_eop[$];
  int          b_cyc[$];
  int          cs_addr[$];
  int          cs_cyc[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_beat = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      issued     = xferred;
      prev_stall = 1'b0;
    end else begin
      if (ram_chipselect) begin
        if (issued - xferred >= FIFO_DEPTH) over_cnt++;
        cs_addr.push_back(int'(ram_address));
        cs_cyc.push_back(cyc);
        cs_cnt++;
      end else if (busy && (issued - xferred == FIFO_DEPTH)) begin
        low_full_cnt++;
      end
      if (prev_stall && (!src_valid || ({src_sop, src_eop, src_data} !== prev_beat))) hold_viol++;
      if (src_valid && src_ready) begin
        b_data.push_back(src_data);
        b_sop.push_back(src_sop);
        b_eop.push_back(src_eop);
        b_cyc.push_back(cyc);
        xferred++;
      end
      if (ram_chipselect) issued++;
      prev_stall = src_valid && !src_ready;
      prev_beat  = {src_sop, src_eop, src_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cmd_err) err_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic issue(input int addr, input int count);
    @(posedge clk); #1;
    cmd_addr  = addr[16:0];
    cmd_count = count[16:0];
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input logic [3:0] pat, input int base, output bit ok);
    int k = 0;
    ok = 1'b0;
    while (k < budget) begin
      @(posedge clk); #1;
      src_ready = pat[k % 4];
      k++;
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
    src_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({busy, done, cmd_err, ram_chipselect, src_valid, src_sop, src_eop} !== 7'b0)
      $display("FAIL reset_outputs: got %b expected 0000000", {busy, done, cmd_err, ram_chipselect, src_valid, src_sop, src_eop});
    else passes++;
    checks++;
    if (ram_address !== 17'h0) $display("FAIL reset_address: got %0h expected 0", ram_address);
    else passes++;
    checks++;
    if (ram_write !== 1'b0 || ram_byteenable !== 4'hF || ram_clken !== 1'b1)
      $display("FAIL ram_constants: got w=%b be=%h ce=%b expected w=0 be=f ce=1", ram_write, ram_byteenable, ram_clken);
    else passes++;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || src_valid !== 1'b0) $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0 0", busy, src_valid);
    else passes++;
  endtask

  task automatic test_basic;
    int bb, cb, db, n;
    bit ok;
    bb = b_data.size(); cb = cs_addr.size(); db = done_cnt;
    src_ready = 1'b1;
    issue(32'h10, 8);
    checks++;
    if (ram_chipselect !== 1'b1 || ram_address !== 17'h10 || busy !== 1'b1)
      $display("FAIL basic_first_issue: got cs=%b addr=%0h busy=%b expected 1 10 1", ram_chipselect, ram_address, busy);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (src_valid !== 1'b0) $display("FAIL basic_valid_t2: got %b expected 0", src_valid);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (src_valid !== 1'b1 || src_sop !== 1'b1 || src_data !== word_of(32'h10))
      $display("FAIL basic_valid_t3: got v=%b sop=%b d=%h expected 1 1 %h", src_valid, src_sop, src_data, word_of(32'h10));
    else passes++;
    run_until_done(100, 4'hF, db, ok);
    checks++;
    if (!ok) $display("FAIL basic_timeout: got no done expected done");
    else passes++;
    repeat (4) @(posedge clk); #1;
    n = b_data.size() - bb;
    checks++;
    if (n !== 8) $display("FAIL basic_beats: got %0d expected 8", n);
    else passes++;
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++;
      if (b_data[bb+i] !== word_of(16 + i) || b_sop[bb+i] !== (i == 0) || b_eop[bb+i] !== (i == 7))
        $display("FAIL basic_beat%0d: got d=%h sop=%b eop=%b expected %h %b %b", i, b_data[bb+i], b_sop[bb+i], b_eop[bb+i], word_of(16 + i), i == 0, i == 7);
      else passes++;
    end
    checks++;
    if (cs_addr.size() - cb !== 8) $display("FAIL basic_issue_count: got %0d expected 8", cs_addr.size() - cb);
    else passes++;
    for (int i = 0; i < 8 && cb + i < cs_addr.size(); i++) begin
      checks++;
      if (cs_addr[cb+i] !== 16 + i || cs_cyc[cb+i] !== cs_cyc[cb] + i)
        $display("FAIL basic_addr%0d: got %0h@%0d expected %0h@%0d", i, cs_addr[cb+i], cs_cyc[cb+i], 16 + i, cs_cyc[cb] + i);
      else passes++;
    end
    checks++;
    if (n > 0 && done_cyc !== b_cyc[bb+n-1] + 1) $display("FAIL basic_done_timing: got %0d expected %0d", done_cyc, b_cyc[bb+n-1] + 1);
    else passes++;
    checks++;
    if (done_cnt - db !== 1 || busy !== 1'b0) $display("FAIL basic_done_once: got %0d busy=%b expected 1 0", done_cnt - db, busy);
    else passes++;
  endtask

  task automatic test_backpressure;
    int bb, db, oc, hv, lf, n;
    bit ok;
    bb = b_data.size(); db = done_cnt; oc = over_cnt; hv = hold_viol; lf = low_full_cnt;
    issue(32'h100, 16);
    run_until_done(300, 4'b1001, db, ok);
    checks++;
    if (!ok) $display("FAIL bp_timeout: got no done expected done");
    else passes++;
    repeat (4) @(posedge clk); #1;
    n = b_data.size() - bb;
    checks++;
    if (n !== 16) $display("FAIL bp_beats: got %0d expected 16", n);
    else passes++;
    for (int i = 0; i < 16 && i < n; i++) begin
      checks++;
      if (b_data[bb+i] !== word_of(256 + i) || b_sop[bb+i] !== (i == 0) || b_eop[bb+i] !== (i == 15))
        $display("FAIL bp_beat%0d: got d=%h sop=%b eop=%b expected %h %b %b", i, b_data[bb+i], b_sop[bb+i], b_eop[bb+i], word_of(256 + i), i == 0, i == 15);
      else passes++;
    end
    checks++;
    if (over_cnt - oc !== 0) $display("FAIL bp_credit_overrun: got %0d expected 0", over_cnt - oc);
    else passes++;
    checks++;
    if (hold_viol - hv !== 0) $display("FAIL bp_hold_stable: got %0d expected 0", hold_viol - hv);
    else passes++;
    checks++;
    if (low_full_cnt - lf <= 0) $display("FAIL bp_cs_throttled: got %0d expected >0", low_full_cnt - lf);
    else passes++;
    checks++;
    if (done_cnt - db !== 1) $display("FAIL bp_done_once: got %0d expected 1", done_cnt - db);
    else passes++;
  endtask

  task automatic test_range;
    int eb, cb, bc, bb, db, n;
    bit ok;
    eb = err_cnt; cb = cs_cnt; bc = busy_cnt;
    issue(127990, 11);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (err_cnt - eb !== 1) $display("FAIL range_err_pulse: got %0d expected 1", err_cnt - eb);
    else passes++;
    checks++;
    if (cs_cnt - cb !== 0 || busy_cnt - bc !== 0) $display("FAIL range_no_activity: got cs=%0d busy=%0d expected 0 0", cs_cnt - cb, busy_cnt - bc);
    else passes++;
    bb = b_data.size(); db = done_cnt;
    issue(127990, 10);
    run_until_done(100, 4'hF, db, ok);
    repeat (3) @(posedge clk); #1;
    n = b_data.size() - bb;
    checks++;
    if (!ok || n !== 10) $display("FAIL range_accept: got done=%0d beats=%0d expected 1 10", ok, n);
    else passes++;
    checks++;
    if (cs_addr[cs_addr.size()-1] !== 127999) $display("FAIL range_last_addr: got %0d expected 127999", cs_addr[cs_addr.size()-1]);
    else passes++;
    checks++;
    if (n > 0 && (b_data[bb+n-1] !== word_of(127999) || b_eop[bb+n-1] !== 1'b1))
      $display("FAIL range_last_beat: got %h eop=%b expected %h 1", b_data[bb+n-1], b_eop[bb+n-1], word_of(127999));
    else passes++;
    checks++;
    if (err_cnt - eb !== 1) $display("FAIL range_no_extra_err: got %0d expected 1", err_cnt - eb);
    else passes++;
  endtask

  task automatic test_full_range;
    int eb;
    eb = err_cnt;
    issue(1, RAM_WORDS);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (err_cnt - eb !== 1 || busy !== 1'b0) $display("FAIL full_plus1_err: got err=%0d busy=%b expected 1 0", err_cnt - eb, busy);
    else passes++;
    issue(0, RAM_WORDS);
    checks++;
    if (ram_chipselect !== 1'b1 || ram_address !== 17'h0 || busy !== 1'b1)
      $display("FAIL full_accept: got cs=%b addr=%0h busy=%b expected 1 0 1", ram_chipselect, ram_address, busy);
    else passes++;
    repeat (10) @(posedge clk); #1;
    checks++;
    if (err_cnt - eb !== 1 || busy !== 1'b1) $display("FAIL full_running: got err=%0d busy=%b expected 1 1", err_cnt - eb, busy);
    else passes++;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_zero_and_single;
    int bb, cb, db, bc, n;
    bit ok;
    bb = b_data.size(); cb = cs_cnt; db = done_cnt; bc = busy_cnt;
    issue(32'h20, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy);
    else passes++;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (done_cnt - db !== 1 || b_data.size() - bb !== 0 || cs_cnt - cb !== 0 || busy_cnt - bc !== 0)
      $display("FAIL zero_quiet: got done=%0d beats=%0d cs=%0d busy=%0d expected 1 0 0 0", done_cnt - db, b_data.size() - bb, cs_cnt - cb, busy_cnt - bc);
    else passes++;
    db = done_cnt;
    issue(32'h55, 1);
    run_until_done(50, 4'hF, db, ok);
    repeat (3) @(posedge clk); #1;
    n = b_data.size() - bb;
    checks++;
    if (!ok || n !== 1) $display("FAIL single_beats: got done=%0d beats=%0d expected 1 1", ok, n);
    else passes++;
    checks++;
    if (n > 0 && (b_data[bb] !== word_of(32'h55) || b_sop[bb] !== 1'b1 || b_eop[bb] !== 1'b1))
      $display("FAIL single_beat: got d=%h sop=%b eop=%b expected %h 1 1", b_data[bb], b_sop[bb], b_eop[bb], word_of(32'h55));
    else passes++;
  endtask

  task automatic test_back_to_back;
    int bb, cb, db, eb, n, nc;
    bit ok;
    bb = b_data.size(); cb = cs_addr.size(); db = done_cnt; eb = err_cnt;
    issue(32'h200, 6);
    @(posedge clk); #1;
    cmd_addr = 17'h300; cmd_count = 17'd3; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    run_until_done(100, 4'hF, db, ok);
    repeat (8) @(posedge clk); #1;
    n = b_data.size() - bb;
    nc = cs_addr.size() - cb;
    checks++;
    if (!ok || n !== 6 || nc !== 6) $display("FAIL b2b_counts: got done=%0d beats=%0d issues=%0d expected 1 6 6", ok, n, nc);
    else passes++;
    for (int i = 0; i < 6 && i < n && i < nc; i++) begin
      checks++;
      if (b_data[bb+i] !== word_of(512 + i) || cs_addr[cb+i] !== 512 + i)
        $display("FAIL b2b_word%0d: got d=%h a=%0h expected %h %0h", i, b_data[bb+i], cs_addr[cb+i], word_of(512 + i), 512 + i);
      else passes++;
    end
    checks++;
    if (done_cnt - db !== 1 || err_cnt - eb !== 0) $display("FAIL b2b_pulses: got done=%0d err=%0d expected 1 0", done_cnt - db, err_cnt - eb);
    else passes++;
  endtask

  task automatic test_reset_mid_packet;
    int bb, db, n, k;
    bit ok, got3;
    bb = b_data.size();
    src_ready = 1'b1;
    issue(32'h400, 20);
    got3 = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (b_data.size() - bb >= 3) begin
        got3 = 1'b1;
        break;
      end
    end
    checks++;
    if (!got3) $display("FAIL mid_timeout: got %0d beats expected 3", b_data.size() - bb);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, cmd_err, ram_chipselect, src_valid, src_sop, src_eop} !== 7'b0 || ram_address !== 17'h0)
      $display("FAIL mid_reset_outputs: got %b addr=%0h expected 0000000 0", {busy, done, cmd_err, ram_chipselect, src_valid, src_sop, src_eop}, ram_address);
    else passes++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    n = b_data.size() - bb;
    checks++;
    if (n !== 3 || b_eop[bb] !== 1'b0 || b_eop[bb+1] !== 1'b0 || b_eop[bb+2] !== 1'b0)
      $display("FAIL mid_abandoned: got beats=%0d expected 3 without eop", n);
    else passes++;
    bb = b_data.size(); db = done_cnt;
    issue(32'h500, 4);
    run_until_done(50, 4'hF, db, ok);
    repeat (3) @(posedge clk); #1;
    n = b_data.size() - bb;
    checks++;
    if (!ok || n !== 4) $display("FAIL mid_restart_count: got done=%0d beats=%0d expected 1 4", ok, n);
    else passes++;
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (b_data[bb+i] !== word_of(1280 + i) || b_sop[bb+i] !== (i == 0) || b_eop[bb+i] !== (i == 3))
        $display("FAIL mid_restart_beat%0d: got d=%h sop=%b eop=%b expected %h %b %b", i, b_data[bb+i], b_sop[bb+i], b_eop[bb+i], word_of(1280 + i), i == 0, i == 3);
      else passes++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_range();
    test_full_range();
    test_zero_and_single();
    test_back_to_back();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/testbench_ls_ram_stream_reader.md
Name: testbench_ls_ram_stream_reader

Overview:
- Avalon-MM read master that sits directly upstream of the 128000 x 32 system RAM slave (17-bit word address, single port, unregistered q).
- On a command, fetches a contiguous word range from the RAM and emits it as an Avalon-ST packet with backpressure.
- Used by the testbench to replay stored L0 primitive/trigger patterns out of RAM.

Parameters:
- RAM_AW, 17, RAM word-address width
- RAM_WORDS, 128000, number of valid RAM words; addresses >= RAM_WORDS are illegal
- FIFO_DEPTH, 4, output buffer depth in words; power of two, >= 2

Ports:
- clk  in  1  single clock shared with the RAM
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  one-cycle start pulse
- cmd_addr  in  RAM_AW  first word address
- cmd_count  in  RAM_AW  number of words to read
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle pulse on a rejected command
- ram_address  out  RAM_AW  to RAM address
- ram_chipselect  out  1  high on a read-issue cycle
- ram_write  out  1  constant 0
- ram_byteenable  out  4  constant 4'hF
- ram_clken  out  1  constant 1
- ram_readdata  in  32  RAM q
- src_data  out  32  stream data
- src_valid  out  1  stream valid
- src_ready  in  1  stream ready
- src_sop  out  1  first word of packet
- src_eop  out  1  last word of packet

Behaviour:
- Reset values: busy=0, done=0, cmd_err=0, ram_address=0, ram_chipselect=0, src_valid=0, src_sop=0, src_eop=0. The FIFO is emptied, all counters are cleared, and the FSM enters IDLE. Reset mid-packet abandons the packet, and no eop is emitted.
- RAM timing: the address/chipselect presented in cycle N gives ram_readdata valid in cycle N+1. The data is written into the FIFO on the edge that ends cycle N+1. The reader tracks this with a 1-bit in-flight flag.
- FSM: IDLE, RUN, DRAIN.
- IDLE transitions on cmd_start:
  - If cmd_addr + cmd_count > RAM_WORDS (computed at RAM_AW+1 bits, no wrap), pulse cmd_err for 1 cycle and stay in IDLE.
  - Else, if cmd_count == 0, pulse done for 1 cycle and stay in IDLE.
  - Else, latch the address and count, set busy=1, and go to RUN.
- cmd_start while busy is ignored, with no err pulse.
- RUN:
  - Issue a read (chipselect=1, address = current address) in any cycle where fifo_used + inflight < FIFO_DEPTH.
  - On each issue, increment the address and decrement the remaining count.
  - After the issue with remaining==1, go to DRAIN.
  - With src_ready held high, throughput is 1 word/cycle.
- DRAIN: when the FIFO is empty and inflight==0, pulse done, clear busy, and return to IDLE.
- Latency: start sampled at edge T0; first ram_address driven in cycle T0+1; src_valid first high in cycle T0+3.
- Stream rules:
  - src_data, src_sop and src_eop are held stable while src_valid=1 and src_ready=0.
  - A word transfers when src_valid && src_ready.
  - src_sop is high on the first word of the packet; src_eop is high on the word that is number cmd_count.
  - Single-word packet: sop and eop are both high.
- FIFO:
  - Show-ahead (first-word fall-through on a registered output).
  - Simultaneous write and read when full is legal.
  - Credit accounting guarantees no overflow, so no overflow path is required.
- Full-range packet: cmd_addr=0, cmd_count=RAM_WORDS is legal. The last address is RAM_WORDS-1, with no wrap.

Decomposition:
- Package testbench_ls_ram_pkg holds:
  - RAM_AW and RAM_WORDS constants
  - the FSM state enum {IDLE, RUN, DRAIN}
- Sub-module testbench_ls_sc_fifo: 32-bit data plus sop/eop sideband, depth FIFO_DEPTH, with show-ahead output and a used-word count output.

Test Plan:
- Reset, then cmd_addr=0x10, cmd_count=8, src_ready=1 -> ram_address 0x10..0x17 on consecutive cycles; 8 beats equal to RAM[0x10..0x17]; sop on beat 0, eop on beat 7; done 1 cycle after the last beat; first src_valid at T0+3.
- cmd_addr=0x100, cmd_count=16, src_ready toggling 1,0,0,1 -> data order correct; no beat lost or duplicated; fifo_used never exceeds 4; chipselect deasserted while credits are exhausted.
- cmd_addr=127990, cmd_count=11 -> cmd_err pulse; no chipselect; busy stays 0. Then cmd_count=10 -> accepted; last address 127999.
- cmd_count=0 -> single done pulse; no stream beats. cmd_count=1 -> one beat with sop=eop=1.
- Second cmd_start during busy -> ignored; the first packet completes unchanged with exactly 1 done pulse.
- Assert reset after 3 beats of a 20-word packet -> all outputs return to reset values within the same cycle. A new 4-word command afterwards streams correctly, starting with sop.
